uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_mem.sv | 24 ++
 rtl/uart_rx_fifo.sv | 113 +++++++++++
 tb/tb_uart_rx_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths, error bit positions and FIFO entry layout for the UART RX path
package uart_pkg;

  localparam int DATA_W      = 8;
  localparam int ERR_W       = 3;
  localparam int ENTRY_W     = ERR_W + DATA_W;
  localparam int ERR_PARITY  = 2;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_FRAME   = 0;

  typedef struct packed {
    logic [ERR_W-1:0]  err;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - DEPTH x ENTRY_W register file, synchronous write, asynchronous read
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_entry,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_entry
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_entry;
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO with sticky overrun, threshold IRQ and character timeout
// Character timeout is built only when UART_RX_TIMEOUT_EN is defined; otherwise timeout_irq is 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int THRESH        = 8,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic [ERR_W-1:0]          rx_err,
  input  logic                      baud_tick,
  input  logic                      rd_en,
  input  logic                      ovr_clr,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ERR_W-1:0]          rd_err,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overrun,
  output logic                      thresh_irq,
  output logic                      timeout_irq
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0]    THRESH_C = THRESH[AW:0];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          ovr_flag, ovr_pend;
  logic          push_acc, pop_acc, ovr_set;
  entry_t        wr_entry, rd_entry;

  assign empty    = (cnt == '0);
  assign full     = (cnt == DEPTH_C);
  assign pop_acc  = rd_en & ~empty;
  assign push_acc = rx_valid & (~full | pop_acc);
  assign ovr_set  = rx_valid & full & ~rd_en;

  // ovr_pend remembers a dropped byte so the next stored entry carries the overrun bit,
  // independently of the host clearing the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ovr_flag <= 1'b0;
      ovr_pend <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (ovr_set)      ovr_flag <= 1'b1;
      else if (ovr_clr) ovr_flag <= 1'b0;
      if (ovr_set)       ovr_pend <= 1'b1;
      else if (push_acc) ovr_pend <= 1'b0;
    end
  end

  always_comb begin
    wr_entry.data              = rx_data;
    wr_entry.err               = rx_err;
    wr_entry.err[ERR_OVERRUN]  = rx_err[ERR_OVERRUN] | ovr_pend;
  end

  uart_rx_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk      (clk),
    .wr_en    (push_acc),
    .wr_addr  (wr_ptr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr),
    .rd_entry (rd_entry)
  );

  assign rd_data    = rd_entry.data;
  assign rd_err     = rd_entry.err;
  assign count      = cnt;
  assign overrun    = ovr_flag;
  assign thresh_irq = (cnt >= THRESH_C);

`ifdef UART_RX_TIMEOUT_EN
  localparam int          TW   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMAX = TIMEOUT_TICKS[TW-1:0];

  logic [TW-1:0] to_cnt;

  // Saturates at TMAX so the IRQ holds until the host touches the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (push_acc || pop_acc || empty) begin
      to_cnt <= '0;
    end else if (baud_tick && (to_cnt != TMAX)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_irq = (to_cnt == TMAX);
`else
  logic unused_timeout;
  assign unused_timeout = baud_tick & (TIMEOUT_TICKS > 0);
  assign timeout_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (DEPTH=16, THRESH=8, TIMEOUT_TICKS=640)
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [2:0]  rx_err = '0;
  logic        baud_tick = 1'b0;
  logic        rd_en = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [7:0]  rd_data;
  logic [2:0]  rd_err;
  logic        empty, full, overrun, thresh_irq, timeout_irq;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q [$];

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .baud_tick(baud_tick), .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data),
    .rd_err(rd_err), .empty(empty), .full(full), .count(count), .overrun(overrun),
    .thresh_irq(thresh_irq), .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after a posedge; return 1ns after the edge that consumed them.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] e,
                     input logic r, input logic c);
    rx_valid = v; rx_data = d; rx_err = e; rd_en = r; ovr_clr = c;
    @(posedge clk); #1;
    rx_valid = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
  endtask

  function automatic logic [2:0] err_of(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b[0], 1'b0, b[1]};
  endfunction

  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry", {rd_err, rd_data});
      end else begin
        check("pop_entry", {rd_err, rd_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_thresh", thresh_irq, 0);
    check("rst_timeout", timeout_irq, 0);

    // Single byte, visible next cycle, popped two cycles after the push
    exp_q.push_back({3'b000, 8'hA5});
    cyc(1, 8'hA5, 3'b000, 0, 0);
    check("fwft_empty", empty, 0);
    check("fwft_data", rd_data, 8'hA5);
    check("fwft_count", count, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("pop_empty", empty, 1);

    // Overfill: 0x00..0x10, the 17th is dropped
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({err_of(i), i[7:0]});
      cyc(1, i[7:0], err_of(i), 0, 0);
    end
    check("ovf_full", full, 1);
    check("ovf_overrun", overrun, 1);
    check("ovf_count", count, 16);
    check("ovf_thresh", thresh_irq, 1);
    cyc(0, 0, 0, 0, 1);
    check("ovr_clr", overrun, 0);
    cyc(0, 0, 0, 1, 0);
    check("count_after_pop", count, 15);
    exp_q.push_back({3'b010, 8'h20});
    cyc(1, 8'h20, 3'b000, 0, 0);
    check("refill_count", count, 16);

    // Push and pop together while full
    exp_q.push_back({3'b001, 8'h21});
    cyc(1, 8'h21, 3'b001, 1, 0);
    check("fullpp_count", count, 16);
    check("fullpp_overrun", overrun, 0);
    check("fullpp_full", full, 1);

    // Drop with ovr_clr in the same cycle: set wins
    cyc(1, 8'h22, 3'b000, 0, 1);
    check("set_wins", overrun, 1);
    check("drop_count", count, 16);

    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0);
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    cyc(0, 0, 0, 1, 0);
    check("pop_on_empty_count", count, 0);
    check("pop_on_empty_empty", empty, 1);

    // Push+pop on empty: push only; carries the overrun mark from the 0x22 drop
    exp_q.push_back({3'b010, 8'h33});
    cyc(1, 8'h33, 3'b000, 1, 0);
    check("emptypp_count", count, 1);
    check("emptypp_empty", empty, 0);
    cyc(0, 0, 0, 1, 0);
    check("emptypp_drained", empty, 1);

    // Threshold
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({3'b100, 8'h40 + k[7:0] - 8'h01});
      cyc(1, 8'h40 + k[7:0] - 8'h01, 3'b100, 0, 0);
      check("thresh_count", count, k);
      check("thresh_level", thresh_irq, (k >= 8) ? 1 : 0);
    end
    cyc(0, 0, 0, 1, 0);
    check("thresh_drop", thresh_irq, 0);
    check("thresh_drop_count", count, 7);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("pre_rst_count", count, 5);

    // Asynchronous reset mid-cycle
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_empty", empty, 1);
    check("arst_count", count, 0);
    check("arst_full", full, 0);
    check("arst_thresh", thresh_irq, 0);
    check("arst_timeout", timeout_irq, 0);
    check("arst_overrun", overrun, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({3'b100, 8'h55});
    cyc(1, 8'h55, 3'b100, 0, 0);
    check("post_rst_count", count, 1);
    cyc(0, 0, 0, 1, 0);
    check("post_rst_empty", empty, 1);

    // Character timeout
    exp_q.push_back({3'b000, 8'h66});
    cyc(1, 8'h66, 3'b000, 0, 0);
    baud_tick = 1'b1;
    repeat (639) cyc(0, 0, 0, 0, 0);
    check("timeout_639", timeout_irq, 0);
    cyc(0, 0, 0, 0, 0);
`ifdef UART_RX_TIMEOUT_EN
    check("timeout_640", timeout_irq, 1);
    repeat (10) cyc(0, 0, 0, 0, 0);
    check("timeout_hold", timeout_irq, 1);
`else
    check("timeout_640", timeout_irq, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    check("timeout_hold", timeout_irq, 0);
`endif
    cyc(0, 0, 0, 1, 0);
    check("timeout_clear", timeout_irq, 0);
    check("timeout_empty", empty, 1);
    baud_tick = 1'b0;

    repeat (3) cyc(0, 0, 0, 0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
